// File: rtl/iob_eth_tx_pkg.sv
// Shared types and constants for the Ethernet MII transmit sequencer.
package iob_eth_tx_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_PRE, ST_SFD, ST_DATA, ST_FCS, ST_IFG} state_t;

  localparam int          PREAMBLE_NIB  = 15;
  localparam logic [3:0]  PREAMBLE      = 4'h5;
  localparam logic [3:0]  SFD           = 4'hD;
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
endpackage

// File: rtl/iob_eth_crc32_nib.sv
// Combinational reflected CRC-32 update by one nibble (LSB first).
// Only built when IOB_ETH_TX_CRC_EN is defined.
`ifdef IOB_ETH_TX_CRC_EN
module iob_eth_crc32_nib
  import iob_eth_tx_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [3:0]  nibble,
  output logic [31:0] crc_out
);
  logic [31:0] c;

  always_comb begin
    c = crc_in ^ {28'd0, nibble};
    for (int i = 0; i < 4; i++)
      c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
    crc_out = c;
  end
endmodule
`endif

// File: rtl/iob_eth_tx_ctrl.sv
// MII transmit sequencer: preamble/SFD, nibble-serialized frame from the TX buffer,
// optional FCS (define IOB_ETH_TX_CRC_EN), then inter-frame gap.
module iob_eth_tx_ctrl #(
  parameter int ADDR_W  = 9,
  parameter int LEN_W   = 11,
  parameter int IFG_NIB = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              send,
  input  logic [LEN_W-1:0]  nbytes,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] buf_addr,
  input  logic [31:0]       buf_data,
  output logic [3:0]        TX_DATA,
  output logic              TX_EN
);
  import iob_eth_tx_pkg::*;

  localparam int CNT_W = $clog2((IFG_NIB > PREAMBLE_NIB ? IFG_NIB : PREAMBLE_NIB) + 1);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_NIB - 1);
  localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(IFG_NIB - 1);

  state_t            state;
  logic [LEN_W-1:0]  bcnt;   // bytes left, including the one on the wire
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        nib;    // nibble index within the current word (or FCS)
  logic [31:0]       sh;     // sh[3:0] is the nibble currently on TX_DATA

`ifdef IOB_ETH_TX_CRC_EN
  logic [31:0] crc, crc_nxt;

  iob_eth_crc32_nib u_crc (
    .crc_in  (crc),
    .nibble  (TX_DATA),
    .crc_out (crc_nxt)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      buf_addr <= '0;
      TX_DATA  <= '0;
      TX_EN    <= 1'b0;
      bcnt     <= '0;
      cnt      <= '0;
      nib      <= '0;
      sh       <= '0;
`ifdef IOB_ETH_TX_CRC_EN
      crc      <= CRC_INIT;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (send && nbytes != '0) begin
          state    <= ST_PRE;
          busy     <= 1'b1;
          buf_addr <= '0;
          bcnt     <= nbytes;
          cnt      <= '0;
          TX_EN    <= 1'b1;
          TX_DATA  <= PREAMBLE;
`ifdef IOB_ETH_TX_CRC_EN
          crc      <= CRC_INIT;
`endif
        end
        ST_PRE: if (cnt == PRE_LAST) begin
          state   <= ST_SFD;
          TX_DATA <= SFD;
        end else begin
          cnt <= cnt + 1'b1;
        end
        // buf_addr has been 0 since the send, so word 0 is already on buf_data
        ST_SFD: begin
          state    <= ST_DATA;
          sh       <= buf_data;
          TX_DATA  <= buf_data[3:0];
          nib      <= '0;
          buf_addr <= buf_addr + 1'b1;
        end
        ST_DATA: begin
`ifdef IOB_ETH_TX_CRC_EN
          crc <= crc_nxt;
`endif
          if (nib[0] && bcnt == LEN_W'(1)) begin
`ifdef IOB_ETH_TX_CRC_EN
            state   <= ST_FCS;
            sh      <= ~crc_nxt;
            TX_DATA <= ~crc_nxt[3:0];
            nib     <= '0;
`else
            state   <= ST_IFG;
            TX_EN   <= 1'b0;
            TX_DATA <= '0;
            cnt     <= '0;
`endif
          end else begin
            if (nib[0]) bcnt <= bcnt - 1'b1;
            if (nib == 3'd7) begin
              sh       <= buf_data;
              TX_DATA  <= buf_data[3:0];
              buf_addr <= buf_addr + 1'b1;
            end else begin
              sh      <= sh >> 4;
              TX_DATA <= sh[7:4];
            end
            nib <= nib + 1'b1;
          end
        end
`ifdef IOB_ETH_TX_CRC_EN
        ST_FCS: if (nib == 3'd7) begin
          state   <= ST_IFG;
          TX_EN   <= 1'b0;
          TX_DATA <= '0;
          cnt     <= '0;
        end else begin
          sh      <= sh >> 4;
          TX_DATA <= sh[7:4];
          nib     <= nib + 1'b1;
        end
`endif
        ST_IFG: if (cnt == IFG_LAST) begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_iob_eth_tx_ctrl.sv
// Table-driven bench for iob_eth_tx_ctrl plus reset, ignored-send and back-to-back sequences.
module tb_iob_eth_tx_ctrl;
  localparam int ADDR_W  = 9;
  localparam int LEN_W   = 11;
  localparam int IFG_NIB = 24;
`ifdef IOB_ETH_TX_CRC_EN
  localparam int FCS_NIB = 8;
`else
  localparam int FCS_NIB = 0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              send = 1'b0;
  logic [LEN_W-1:0]  nbytes = '0;
  logic              busy, done, TX_EN;
  logic [ADDR_W-1:0] buf_addr;
  logic [31:0]       buf_data = '0;
  logic [3:0]        TX_DATA;

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  iob_eth_tx_ctrl #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .IFG_NIB(IFG_NIB)) dut (
    .clk(clk), .rst(rst), .send(send), .nbytes(nbytes), .busy(busy), .done(done),
    .buf_addr(buf_addr), .buf_data(buf_data), .TX_DATA(TX_DATA), .TX_EN(TX_EN)
  );

  always #5 clk = ~clk;
  always @(posedge clk) buf_data <= mem[buf_addr];

  typedef struct {
    int           n;
    logic [31:0]  w0, w1, w2;
    logic [127:0] exp;      // data nibbles in wire order, first nibble most significant
    int           max_addr;
    logic         chk_fcs;
    logic [31:0]  fcs;      // FCS nibbles, first on the wire in bits [3:0]
  } vec_t;

  int errs = 0, nchk = 0;

  logic [127:0] r_dcap;
  logic [31:0]  r_fcap;
  int           r_fall, r_done, r_max;
  logic         r_pre_ok, r_sfd_ok, r_ifg_ok, r_busy_ok, r_busy_done;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic load(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
    mem[0] = w0; mem[1] = w1; mem[2] = w2; mem[3] = 32'hDEADBEEF;
  endtask

  // Call at a negedge; send is presented immediately. Returns at the negedge of the done cycle.
  task automatic run_frame(input int n, input int poke_cyc);
    send = 1'b1; nbytes = LEN_W'(n);
    r_dcap = '0; r_fcap = '0; r_fall = -1; r_done = -1; r_max = 0;
    r_pre_ok = 1'b1; r_sfd_ok = 1'b0; r_ifg_ok = 1'b1; r_busy_ok = 1'b1; r_busy_done = 1'b1;
    @(posedge clk);
    @(negedge clk);
    send = 1'b0;
    for (int c = 1; c < 3000; c++) begin
      if (c <= 15) r_pre_ok = r_pre_ok & TX_EN & (TX_DATA == 4'h5);
      else if (c == 16) r_sfd_ok = TX_EN & (TX_DATA == 4'hD);
      else if (c <= 16 + 2*n) r_dcap = {r_dcap[123:0], TX_DATA};
      else if (c <= 16 + 2*n + FCS_NIB) r_fcap = {TX_DATA, r_fcap[31:4]};
      if (c > 16 && r_fall < 0 && !TX_EN) r_fall = c;
      if (r_fall >= 0 && (TX_EN || TX_DATA != 4'h0)) r_ifg_ok = 1'b0;
      if (int'(buf_addr) > r_max) r_max = int'(buf_addr);
      if (done) begin
        r_done = c; r_busy_done = busy;
        break;
      end
      if (!busy) r_busy_ok = 1'b0;
      send = (c == poke_cyc);
      @(negedge clk);
    end
    send = 1'b0;
  endtask

  task automatic check_frame(input string tag, input vec_t v);
    chk({tag, "_pre"}, r_pre_ok, 1'b1);
    chk({tag, "_sfd"}, r_sfd_ok, 1'b1);
    chk({tag, "_data"}, r_dcap, v.exp);
`ifdef IOB_ETH_TX_CRC_EN
    if (v.chk_fcs) chk({tag, "_fcs"}, r_fcap, v.fcs);
`endif
    chk({tag, "_en_fall"}, r_fall, 17 + 2*v.n + FCS_NIB);
    chk({tag, "_done_cyc"}, r_done, 17 + 2*v.n + FCS_NIB + IFG_NIB);
    chk({tag, "_ifg_idle"}, r_ifg_ok, 1'b1);
    chk({tag, "_busy"}, r_busy_ok, 1'b1);
    chk({tag, "_busy_at_done"}, r_busy_done, 1'b0);
    chk({tag, "_max_addr"}, r_max, v.max_addr);
  endtask

  // Watch an idle window: no TX_EN, no busy, no done.
  task automatic idle_watch(input string nm, input int cycles);
    logic quiet = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (TX_EN || busy || done) quiet = 1'b0;
    end
    chk(nm, quiet, 1'b1);
  endtask

  vec_t vecs [6];
  int   gap;

  initial begin
    for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = 32'hA5A5_0000 | i;
    vecs[0] = '{8,  32'h44332211, 32'h88776655, 32'h0, 128'h1122334455667788, 2, 1'b0, 32'h0};
    vecs[1] = '{5,  32'h44332211, 32'h88776655, 32'h0, 128'h1122334455, 2, 1'b0, 32'h0};
    vecs[2] = '{6,  32'hA1B2C3D4, 32'h0000F00F, 32'h0, 128'h4D3C2B1AF00F, 2, 1'b0, 32'h0};
    vecs[3] = '{1,  32'h000000E7, 32'h0, 32'h0, 128'h7E, 1, 1'b0, 32'h0};
    vecs[4] = '{12, 32'h76543210, 32'hFEDCBA98, 32'h13579BDF,
                128'h0123456789ABCDEFFDB97531, 3, 1'b0, 32'h0};
    vecs[5] = '{9,  32'h34333231, 32'h38373635, 32'h00000039,
                128'h132333435363738393, 3, 1'b1, 32'hCBF43926};

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_addr", buf_addr, '0);
    chk("rst_en", TX_EN, 1'b0);
    chk("rst_data", TX_DATA, 4'h0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      load(vecs[i].w0, vecs[i].w1, vecs[i].w2);
      run_frame(vecs[i].n, -1);
      check_frame($sformatf("v%0d", i), vecs[i]);
      repeat (2) @(negedge clk);
    end

    // send during DATA is ignored, then send with nbytes==0 while idle is ignored
    load(vecs[0].w0, vecs[0].w1, vecs[0].w2);
    run_frame(8, 20);
    check_frame("poke", vecs[0]);
    idle_watch("poke_no_extra", 40);
    send = 1'b1; nbytes = '0;
    @(negedge clk);
    send = 1'b0;
    idle_watch("zero_len_ignored", 40);

    // reset in the middle of a 64-byte frame
    send = 1'b1; nbytes = LEN_W'(64);
    @(posedge clk);
    @(negedge clk);
    send = 1'b0;
    repeat (19) @(negedge clk);
    chk("mid_en_before_rst", TX_EN, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_en", TX_EN, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    idle_watch("post_rst_idle", 5);
    chk("post_rst_addr", buf_addr, '0);
    load(vecs[2].w0, vecs[2].w1, vecs[2].w2);
    run_frame(vecs[2].n, -1);
    check_frame("post_rst", vecs[2]);
    repeat (2) @(negedge clk);

    // back-to-back: next send issued in the done cycle
    load(vecs[0].w0, vecs[0].w1, vecs[0].w2);
    run_frame(8, -1);
    check_frame("b2b_a", vecs[0]);
    gap = (r_done >= 0 && r_fall >= 0) ? r_done - r_fall + 1 : -1;
    chk("b2b_done_seen", done, 1'b1);
    run_frame(8, -1);
    check_frame("b2b_b", vecs[0]);
    chk("b2b_gap", gap, IFG_NIB + 1);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end
endmodule
